// File: rtl/elink_width_converter.sv
// Per-lane AXI-Stream width converter for e-link lanes on clk160.
// Packs (narrow->wide) or unpacks (wide->narrow) by an integer ratio.
module elink_width_converter #(
  parameter int N_LINKS      = 1,
  parameter int INPUT_WIDTH  = 32,
  parameter int OUTPUT_WIDTH = 8,
  parameter bit MSB_FIRST    = 1'b1
) (
  input  logic                            clk160,
  input  logic                            clk160_reset,
  input  logic                            realign,
  input  logic [N_LINKS*INPUT_WIDTH-1:0]  S_AXIS_tdata,
  input  logic                            S_AXIS_tvalid,
  output logic                            S_AXIS_tready,
  output logic [N_LINKS*OUTPUT_WIDTH-1:0] M_AXIS_tdata,
  output logic                            M_AXIS_tvalid,
  input  logic                            M_AXIS_tready,
  output logic [3:0]                      beat_count
);

  localparam int WIDE   = (INPUT_WIDTH > OUTPUT_WIDTH) ?
                          INPUT_WIDTH : OUTPUT_WIDTH;
  localparam int NARROW = (INPUT_WIDTH > OUTPUT_WIDTH) ?
                          OUTPUT_WIDTH : INPUT_WIDTH;
  localparam int RATIO  = (NARROW > 0) ? WIDE / NARROW : 0;

  generate
    if (NARROW < 1 || (WIDE % NARROW) != 0 ||
        RATIO < 1 || RATIO > 16) begin : g_bad_cfg
      $error("elink_width_converter: widths must differ by 1..16x");
    end
  endgenerate

  generate
    if (RATIO == 1) begin : g_bypass
      logic                            vld;
      logic [N_LINKS*OUTPUT_WIDTH-1:0] dat;

      assign S_AXIS_tready = !clk160_reset && !realign &&
                             (!vld || M_AXIS_tready);
      assign M_AXIS_tvalid = vld;
      assign M_AXIS_tdata  = dat;
      assign beat_count    = 4'd0;

      always_ff @(posedge clk160) begin
        if (clk160_reset) begin
          vld <= 1'b0;
          dat <= '0;
        end else if (S_AXIS_tvalid && S_AXIS_tready) begin
          vld <= 1'b1;
          dat <= S_AXIS_tdata;
        end else if (M_AXIS_tready) begin
          vld <= 1'b0;
        end
      end

    end else if (INPUT_WIDTH > OUTPUT_WIDTH) begin : g_down
      localparam logic [3:0] LAST = 4'(RATIO - 1);

      logic [N_LINKS*INPUT_WIDTH-1:0] hold;
      logic                           full;
      logic [3:0]                     cnt;
      logic [3:0]                     slice;
      logic                           last;
      logic                           s_hs;
      logic                           m_hs;

      assign last  = (cnt == LAST);
      assign slice = MSB_FIRST ? (LAST - cnt) : cnt;

      // A new word may enter on the cycle the last beat leaves.
      assign S_AXIS_tready = !clk160_reset && !realign &&
                             (!full || (M_AXIS_tready && last));
      assign s_hs = S_AXIS_tvalid && S_AXIS_tready;
      assign m_hs = full && M_AXIS_tready;

      assign M_AXIS_tvalid = full;
      assign beat_count    = cnt;

      always_comb begin
        M_AXIS_tdata = '0;
        for (int i = 0; i < N_LINKS; i++) begin
          M_AXIS_tdata[i*OUTPUT_WIDTH +: OUTPUT_WIDTH] =
            hold[i*INPUT_WIDTH + int'(slice)*OUTPUT_WIDTH +: OUTPUT_WIDTH];
        end
      end

      always_ff @(posedge clk160) begin
        if (clk160_reset) begin
          hold <= '0;
          full <= 1'b0;
          cnt  <= 4'd0;
        end else if (realign) begin
          full <= 1'b0;
          cnt  <= 4'd0;
        end else if (s_hs) begin
          hold <= S_AXIS_tdata;
          full <= 1'b1;
          cnt  <= 4'd0;
        end else if (m_hs) begin
          if (last) begin
            full <= 1'b0;
            cnt  <= 4'd0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
      end

    end else begin : g_up
      localparam logic [3:0] LAST = 4'(RATIO - 1);

      logic [N_LINKS*OUTPUT_WIDTH-1:0] asm_q;
      logic [N_LINKS*OUTPUT_WIDTH-1:0] nxt;
      logic [N_LINKS*OUTPUT_WIDTH-1:0] odat;
      logic                            ovld;
      logic [3:0]                      cnt;
      logic [3:0]                      slice;
      logic                            last;
      logic                            s_hs;
      logic                            m_hs;

      assign last  = (cnt == LAST);
      assign slice = MSB_FIRST ? (LAST - cnt) : cnt;

      // Only the completing beat needs room in the output register.
      assign S_AXIS_tready = !clk160_reset && !realign &&
                             (!last || !ovld || M_AXIS_tready);
      assign s_hs = S_AXIS_tvalid && S_AXIS_tready;
      assign m_hs = ovld && M_AXIS_tready;

      assign M_AXIS_tvalid = ovld;
      assign M_AXIS_tdata  = odat;
      assign beat_count    = cnt;

      always_comb begin
        nxt = asm_q;
        for (int i = 0; i < N_LINKS; i++) begin
          nxt[i*OUTPUT_WIDTH + int'(slice)*INPUT_WIDTH +: INPUT_WIDTH] =
            S_AXIS_tdata[i*INPUT_WIDTH +: INPUT_WIDTH];
        end
      end

      always_ff @(posedge clk160) begin
        if (clk160_reset) begin
          asm_q <= '0;
          odat  <= '0;
          ovld  <= 1'b0;
          cnt   <= 4'd0;
        end else begin
          if (m_hs) begin
            ovld <= 1'b0;
          end
          if (realign) begin
            asm_q <= '0;
            cnt   <= 4'd0;
          end else if (s_hs) begin
            if (last) begin
              odat  <= nxt;
              ovld  <= 1'b1;
              asm_q <= '0;
              cnt   <= 4'd0;
            end else begin
              asm_q <= nxt;
              cnt   <= cnt + 4'd1;
            end
          end
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_elink_width_converter.sv
// Bench for elink_width_converter: directed down/up/realign/reset/
// bypass cases plus randomised backpressure against a scoreboard.
module tb_elink_width_converter;

  logic clk160 = 1'b0;
  logic rst;
  logic realign;
  int   checks;
  int   errors;

  always #5 clk160 = ~clk160;

  // down 32->8, two lanes, MSB first
  logic [63:0] d_sd;
  logic        d_sv, d_sr, d_mv, d_mr;
  logic [15:0] d_md;
  logic [3:0]  d_bc;
  elink_width_converter #(.N_LINKS(2), .INPUT_WIDTH(32),
    .OUTPUT_WIDTH(8), .MSB_FIRST(1'b1)) u_d0 (
    .clk160(clk160), .clk160_reset(rst), .realign(realign),
    .S_AXIS_tdata(d_sd), .S_AXIS_tvalid(d_sv), .S_AXIS_tready(d_sr),
    .M_AXIS_tdata(d_md), .M_AXIS_tvalid(d_mv), .M_AXIS_tready(d_mr),
    .beat_count(d_bc));

  // up 8->32, LSB first
  logic [7:0]  u_sd;
  logic        u_sv, u_sr, u_mv, u_mr;
  logic [31:0] u_md;
  logic [3:0]  u_bc;
  elink_width_converter #(.N_LINKS(1), .INPUT_WIDTH(8),
    .OUTPUT_WIDTH(32), .MSB_FIRST(1'b0)) u_u0 (
    .clk160(clk160), .clk160_reset(rst), .realign(realign),
    .S_AXIS_tdata(u_sd), .S_AXIS_tvalid(u_sv), .S_AXIS_tready(u_sr),
    .M_AXIS_tdata(u_md), .M_AXIS_tvalid(u_mv), .M_AXIS_tready(u_mr),
    .beat_count(u_bc));

  // up 8->32, MSB first (realign)
  logic [7:0]  a_sd;
  logic        a_sv, a_sr, a_mv, a_mr;
  logic [31:0] a_md;
  logic [3:0]  a_bc;
  elink_width_converter #(.N_LINKS(1), .INPUT_WIDTH(8),
    .OUTPUT_WIDTH(32), .MSB_FIRST(1'b1)) u_a0 (
    .clk160(clk160), .clk160_reset(rst), .realign(realign),
    .S_AXIS_tdata(a_sd), .S_AXIS_tvalid(a_sv), .S_AXIS_tready(a_sr),
    .M_AXIS_tdata(a_md), .M_AXIS_tvalid(a_mv), .M_AXIS_tready(a_mr),
    .beat_count(a_bc));

  // bypass 8->8
  logic [7:0] b_sd;
  logic       b_sv, b_sr, b_mv, b_mr;
  logic [7:0] b_md;
  logic [3:0] b_bc;
  elink_width_converter #(.N_LINKS(1), .INPUT_WIDTH(8),
    .OUTPUT_WIDTH(8), .MSB_FIRST(1'b1)) u_b0 (
    .clk160(clk160), .clk160_reset(rst), .realign(realign),
    .S_AXIS_tdata(b_sd), .S_AXIS_tvalid(b_sv), .S_AXIS_tready(b_sr),
    .M_AXIS_tdata(b_md), .M_AXIS_tvalid(b_mv), .M_AXIS_tready(b_mr),
    .beat_count(b_bc));

  // random backpressure set: down x2,x4,x8 then up x2,x4,x8
  int RIN  [6] = '{16, 32, 64, 8, 8, 8};
  int ROUT [6] = '{8, 8, 8, 16, 32, 64};
  bit RMSB [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

  logic        rsv;
  logic [63:0] rsd;
  logic        rmr [6];
  logic        rsr [6];
  logic        rmv [6];
  logic [3:0]  rbc [6];
  logic [63:0] rmd [6];
  logic [7:0]  r0_md, r1_md, r2_md;
  logic [15:0] r3_md;
  logic [31:0] r4_md;
  logic [63:0] r5_md;

  assign rmd[0] = {56'd0, r0_md};
  assign rmd[1] = {56'd0, r1_md};
  assign rmd[2] = {56'd0, r2_md};
  assign rmd[3] = {48'd0, r3_md};
  assign rmd[4] = {32'd0, r4_md};
  assign rmd[5] = r5_md;

  elink_width_converter #(.N_LINKS(1), .INPUT_WIDTH(16),
    .OUTPUT_WIDTH(8), .MSB_FIRST(1'b1)) u_r0 (
    .clk160(clk160), .clk160_reset(rst), .realign(realign),
    .S_AXIS_tdata(rsd[15:0]), .S_AXIS_tvalid(rsv),
    .S_AXIS_tready(rsr[0]), .M_AXIS_tdata(r0_md),
    .M_AXIS_tvalid(rmv[0]), .M_AXIS_tready(rmr[0]),
    .beat_count(rbc[0]));
  elink_width_converter #(.N_LINKS(1), .INPUT_WIDTH(32),
    .OUTPUT_WIDTH(8), .MSB_FIRST(1'b0)) u_r1 (
    .clk160(clk160), .clk160_reset(rst), .realign(realign),
    .S_AXIS_tdata(rsd[31:0]), .S_AXIS_tvalid(rsv),
    .S_AXIS_tready(rsr[1]), .M_AXIS_tdata(r1_md),
    .M_AXIS_tvalid(rmv[1]), .M_AXIS_tready(rmr[1]),
    .beat_count(rbc[1]));
  elink_width_converter #(.N_LINKS(1), .INPUT_WIDTH(64),
    .OUTPUT_WIDTH(8), .MSB_FIRST(1'b1)) u_r2 (
    .clk160(clk160), .clk160_reset(rst), .realign(realign),
    .S_AXIS_tdata(rsd), .S_AXIS_tvalid(rsv),
    .S_AXIS_tready(rsr[2]), .M_AXIS_tdata(r2_md),
    .M_AXIS_tvalid(rmv[2]), .M_AXIS_tready(rmr[2]),
    .beat_count(rbc[2]));
  elink_width_converter #(.N_LINKS(1), .INPUT_WIDTH(8),
    .OUTPUT_WIDTH(16), .MSB_FIRST(1'b0)) u_r3 (
    .clk160(clk160), .clk160_reset(rst), .realign(realign),
    .S_AXIS_tdata(rsd[7:0]), .S_AXIS_tvalid(rsv),
    .S_AXIS_tready(rsr[3]), .M_AXIS_tdata(r3_md),
    .M_AXIS_tvalid(rmv[3]), .M_AXIS_tready(rmr[3]),
    .beat_count(rbc[3]));
  elink_width_converter #(.N_LINKS(1), .INPUT_WIDTH(8),
    .OUTPUT_WIDTH(32), .MSB_FIRST(1'b1)) u_r4 (
    .clk160(clk160), .clk160_reset(rst), .realign(realign),
    .S_AXIS_tdata(rsd[7:0]), .S_AXIS_tvalid(rsv),
    .S_AXIS_tready(rsr[4]), .M_AXIS_tdata(r4_md),
    .M_AXIS_tvalid(rmv[4]), .M_AXIS_tready(rmr[4]),
    .beat_count(rbc[4]));
  elink_width_converter #(.N_LINKS(1), .INPUT_WIDTH(8),
    .OUTPUT_WIDTH(64), .MSB_FIRST(1'b0)) u_r5 (
    .clk160(clk160), .clk160_reset(rst), .realign(realign),
    .S_AXIS_tdata(rsd[7:0]), .S_AXIS_tvalid(rsv),
    .S_AXIS_tready(rsr[5]), .M_AXIS_tdata(r5_md),
    .M_AXIS_tvalid(rmv[5]), .M_AXIS_tready(rmr[5]),
    .beat_count(rbc[5]));

  function automatic logic [63:0] msk(input int w);
    return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
  endfunction

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk160);
    #1;
    checks++;
    if ({d_mv, u_mv, a_mv, b_mv} !== 4'b0) begin
      errors++;
      $display("FAIL reset_mvalid: got %b, required 0000",
               {d_mv, u_mv, a_mv, b_mv});
    end
    checks++;
    if ({d_md, u_md, a_md, b_md} !== 88'd0) begin
      errors++;
      $display("FAIL reset_mdata: got %h %h %h %h, required 0",
               d_md, u_md, a_md, b_md);
    end
    checks++;
    if ({d_sr, u_sr, a_sr, b_sr} !== 4'b0) begin
      errors++;
      $display("FAIL reset_sready: got %b, required 0000",
               {d_sr, u_sr, a_sr, b_sr});
    end
    checks++;
    if ({d_bc, u_bc, a_bc, b_bc} !== 16'd0) begin
      errors++;
      $display("FAIL reset_beat: got %h, required 0",
               {d_bc, u_bc, a_bc, b_bc});
    end
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (rmv[k] !== 1'b0 || rsr[k] !== 1'b0 || rbc[k] !== 4'd0) begin
        errors++;
        $display("FAIL reset_r%0d: mv %b sr %b bc %0d, required 0 0 0",
                 k, rmv[k], rsr[k], rbc[k]);
      end
    end
    @(negedge clk160);
    rst = 1'b0;
    #1;
    checks++;
    if ({d_sr, u_sr, a_sr, b_sr} !== 4'b1111) begin
      errors++;
      $display("FAIL reset_release_ready: got %b, required 1111",
               {d_sr, u_sr, a_sr, b_sr});
    end
  endtask

  task automatic test_down;
    logic [63:0] words [2];
    logic [15:0] dq [$];
    logic [15:0] exp;
    int          wi;
    int          seen;
    bit          started;
    words[0] = {32'h11223344, 32'hA1B2C3D4};
    words[1] = {32'h99AABBCC, 32'h55667788};
    wi = 0;
    seen = 0;
    started = 1'b0;
    for (int cyc = 0; cyc < 40 && seen < 8; cyc++) begin
      @(negedge clk160);
      d_mr = 1'b1;
      if (wi < 2) begin
        d_sv = 1'b1;
        d_sd = words[wi];
      end else begin
        d_sv = 1'b0;
      end
      #1;
      if (d_mv) begin
        started = 1'b1;
        checks++;
        if (dq.size() == 0) begin
          errors++;
          $display("FAIL down_beat: got %h, required no beat", d_md);
        end else begin
          exp = dq.pop_front();
          if (d_md !== exp) begin
            errors++;
            $display("FAIL down_beat%0d: got %h, required %h",
                     seen, d_md, exp);
          end
        end
        seen++;
      end else if (started) begin
        checks++;
        errors++;
        $display("FAIL down_bubble: tvalid 0 after %0d beats, required 1",
                 seen);
      end
      if (d_sv && d_sr) begin
        for (int b = 0; b < 4; b++) begin
          int s;
          s = 3 - b;
          dq.push_back({d_sd[32 + s*8 +: 8], d_sd[s*8 +: 8]});
        end
        wi++;
      end
    end
    d_sv = 1'b0;
    checks++;
    if (seen != 8) begin
      errors++;
      $display("FAIL down_count: got %0d beats, required 8", seen);
    end
  endtask

  task automatic test_reset_midword;
    @(negedge clk160);
    d_mr = 1'b1;
    d_sv = 1'b1;
    d_sd = {32'h01234567, 32'hDEADBEEF};
    #1;
    checks++;
    if (d_sr !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_accept: sready %b, required 1", d_sr);
    end
    @(negedge clk160);
    d_sv = 1'b0;
    #1;
    checks++;
    if (d_mv !== 1'b1 || d_md !== 16'h01DE) begin
      errors++;
      $display("FAIL rstmid_beat0: mv %b data %h, required 1 01de",
               d_mv, d_md);
    end
    @(negedge clk160);
    @(negedge clk160);
    rst = 1'b1;
    #1;
    checks++;
    if (d_bc !== 4'd2 || d_md !== 16'h45BE) begin
      errors++;
      $display("FAIL rstmid_beat2: bc %0d data %h, required 2 45be",
               d_bc, d_md);
    end
    checks++;
    if (d_sr !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_ready_in_rst: got %b, required 0", d_sr);
    end
    @(negedge clk160);
    #1;
    checks++;
    if (d_mv !== 1'b0 || d_md !== 16'h0 || d_bc !== 4'd0) begin
      errors++;
      $display("FAIL rstmid_cleared: mv %b data %h bc %0d, required 0 0 0",
               d_mv, d_md, d_bc);
    end
    checks++;
    if (d_sr !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_ready_held: got %b, required 0", d_sr);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (d_sr !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_ready_after: got %b, required 1", d_sr);
    end
  endtask

  task automatic test_up;
    u_mr = 1'b1;
    for (int b = 1; b <= 4; b++) begin
      @(negedge clk160);
      u_sv = 1'b1;
      u_sd = 8'(b);
      #1;
      checks++;
      if (u_sr !== 1'b1 || u_mv !== 1'b0) begin
        errors++;
        $display("FAIL up_fill%0d: sr %b mv %b, required 1 0",
                 b, u_sr, u_mv);
      end
    end
    for (int b = 5; b <= 10; b++) begin
      @(negedge clk160);
      u_mr = 1'b0;
      u_sv = 1'b1;
      u_sd = 8'((b > 8) ? 8 : b);
      #1;
      checks++;
      if (u_sr !== (b < 8)) begin
        errors++;
        $display("FAIL up_stall_ready%0d: got %b, required %b",
                 b, u_sr, (b < 8));
      end
      checks++;
      if (u_mv !== 1'b1 || u_md !== 32'h04030201) begin
        errors++;
        $display("FAIL up_word0_%0d: mv %b data %h, required 1 04030201",
                 b, u_mv, u_md);
      end
    end
    @(negedge clk160);
    u_mr = 1'b1;
    #1;
    checks++;
    if (u_sr !== 1'b1) begin
      errors++;
      $display("FAIL up_release_ready: got %b, required 1", u_sr);
    end
    @(negedge clk160);
    u_sv = 1'b0;
    #1;
    checks++;
    if (u_mv !== 1'b1 || u_md !== 32'h08070605) begin
      errors++;
      $display("FAIL up_word1: mv %b data %h, required 1 08070605",
               u_mv, u_md);
    end
    @(negedge clk160);
    #1;
    checks++;
    if (u_mv !== 1'b0) begin
      errors++;
      $display("FAIL up_drain: mv %b, required 0", u_mv);
    end
  endtask

  task automatic test_realign;
    logic [7:0] beats [7];
    beats = '{8'hAA, 8'hBB, 8'hCC, 8'h01, 8'h02, 8'h03, 8'h04};
    a_mr = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk160);
      a_sv = 1'b1;
      a_sd = beats[i];
      realign = (i == 2);
      #1;
      if (i == 2) begin
        checks++;
        if (a_sr !== 1'b0) begin
          errors++;
          $display("FAIL realign_ready: got %b, required 0", a_sr);
        end
        checks++;
        if (a_bc !== 4'd2) begin
          errors++;
          $display("FAIL realign_pre_bc: got %0d, required 2", a_bc);
        end
      end
      if (i == 3) begin
        checks++;
        if (a_bc !== 4'd0) begin
          errors++;
          $display("FAIL realign_bc: got %0d, required 0", a_bc);
        end
      end
      if (a_mv) begin
        checks++;
        errors++;
        $display("FAIL realign_early: word %h, required none", a_md);
      end
    end
    @(negedge clk160);
    a_sv = 1'b0;
    realign = 1'b0;
    #1;
    checks++;
    if (a_mv !== 1'b1 || a_md !== 32'h01020304) begin
      errors++;
      $display("FAIL realign_word: mv %b data %h, required 1 01020304",
               a_mv, a_md);
    end
    @(negedge clk160);
    #1;
    checks++;
    if (a_mv !== 1'b0) begin
      errors++;
      $display("FAIL realign_extra: mv %b data %h, required 0",
               a_mv, a_md);
    end
  endtask

  task automatic test_bypass;
    logic [7:0] bq [$];
    logic [7:0] exp;
    logic [7:0] last_in;
    logic [7:0] pdat;
    bit         prev_hs;
    bit         pstall;
    int         nxt;
    int         got;
    prev_hs = 1'b0;
    pstall = 1'b0;
    last_in = 8'd0;
    pdat = 8'd0;
    nxt = 0;
    got = 0;
    for (int cyc = 0; cyc < 2000 && got < 256; cyc++) begin
      @(negedge clk160);
      if (prev_hs) begin
        checks++;
        if (b_mv !== 1'b1 || b_md !== last_in) begin
          errors++;
          $display("FAIL bypass_latency: mv %b data %h, required 1 %h",
                   b_mv, b_md, last_in);
        end
      end
      if (pstall) begin
        checks++;
        if (b_mv !== 1'b1 || b_md !== pdat) begin
          errors++;
          $display("FAIL bypass_stall: mv %b data %h, required 1 %h",
                   b_mv, b_md, pdat);
        end
      end
      b_mr = (cyc % 3) != 0;
      b_sv = nxt < 256;
      b_sd = 8'(nxt);
      #1;
      if (b_mv && b_mr) begin
        checks++;
        if (bq.size() == 0) begin
          errors++;
          $display("FAIL bypass_order: got %h, required no output", b_md);
        end else begin
          exp = bq.pop_front();
          if (b_md !== exp) begin
            errors++;
            $display("FAIL bypass_order: got %h, required %h", b_md, exp);
          end
        end
        got++;
      end
      prev_hs = b_sv && b_sr;
      if (prev_hs) begin
        bq.push_back(b_sd);
        last_in = b_sd;
        nxt++;
      end
      pstall = b_mv && !b_mr;
      pdat = b_md;
    end
    b_sv = 1'b0;
    checks++;
    if (got != 256 || b_bc !== 4'd0) begin
      errors++;
      $display("FAIL bypass_count: got %0d words bc %0d, required 256 0",
               got, b_bc);
    end
  endtask

  task automatic test_backpressure;
    logic [63:0] rq [6][$];
    logic [63:0] acc [6];
    logic [63:0] pdat [6];
    int          cnt [6];
    int          words [6];
    bit          pstall [6];
    logic [63:0] w;
    logic [63:0] exp;
    int          s;
    int          r;
    bit          done;
    for (int k = 0; k < 6; k++) begin
      acc[k] = '0;
      pdat[k] = '0;
      cnt[k] = 0;
      words[k] = 0;
      pstall[k] = 1'b0;
    end
    done = 1'b0;
    for (int cyc = 0; cyc < 40000 && !done; cyc++) begin
      @(negedge clk160);
      for (int k = 0; k < 6; k++) begin
        if (pstall[k]) begin
          checks++;
          if (rmv[k] !== 1'b1 || rmd[k] !== pdat[k]) begin
            errors++;
            $display("FAIL bp_stall%0d: mv %b data %h, required 1 %h",
                     k, rmv[k], rmd[k], pdat[k]);
          end
        end
      end
      rsv = $urandom_range(0, 3) != 0;
      rsd = {$urandom(), $urandom()};
      for (int k = 0; k < 6; k++) rmr[k] = $urandom_range(0, 1) == 1;
      #1;
      for (int k = 0; k < 6; k++) begin
        if (rmv[k] && rmr[k]) begin
          checks++;
          if (rq[k].size() == 0) begin
            errors++;
            $display("FAIL bp_data%0d: got %h, required no output",
                     k, rmd[k]);
          end else begin
            exp = rq[k].pop_front();
            if (rmd[k] !== exp) begin
              errors++;
              $display("FAIL bp_data%0d: got %h, required %h",
                       k, rmd[k], exp);
            end
          end
          if (RIN[k] < ROUT[k]) words[k]++;
        end
        if (rsv && rsr[k]) begin
          w = rsd & msk(RIN[k]);
          if (RIN[k] > ROUT[k]) begin
            r = RIN[k] / ROUT[k];
            for (int b = 0; b < r; b++) begin
              s = RMSB[k] ? (r - 1 - b) : b;
              rq[k].push_back((w >> (s * ROUT[k])) & msk(ROUT[k]));
            end
            words[k]++;
          end else begin
            r = ROUT[k] / RIN[k];
            s = RMSB[k] ? (r - 1 - cnt[k]) : cnt[k];
            acc[k] = acc[k] | (w << (s * RIN[k]));
            cnt[k]++;
            if (cnt[k] == r) begin
              rq[k].push_back(acc[k]);
              acc[k] = '0;
              cnt[k] = 0;
            end
          end
        end
        pstall[k] = rmv[k] && !rmr[k];
        pdat[k] = rmd[k];
      end
      done = 1'b1;
      for (int k = 0; k < 6; k++) if (words[k] < 1000) done = 1'b0;
    end
    rsv = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL bp_timeout: words %0d %0d %0d %0d %0d %0d, required 1000 each",
               words[0], words[1], words[2], words[3], words[4], words[5]);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    realign = 1'b0;
    d_sd = '0; d_sv = 1'b0; d_mr = 1'b0;
    u_sd = '0; u_sv = 1'b0; u_mr = 1'b0;
    a_sd = '0; a_sv = 1'b0; a_mr = 1'b0;
    b_sd = '0; b_sv = 1'b0; b_mr = 1'b0;
    rsd = '0; rsv = 1'b0;
    for (int k = 0; k < 6; k++) rmr[k] = 1'b0;
    test_reset();
    test_down();
    test_reset_midword();
    test_up();
    test_realign();
    test_bypass();
    test_backpressure();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
